final_reduce: RTL and testbench

FINAL_REDUCE -- requirements
Module: final_reduce

---
 rtl/final_reduce.sv | 108 ++++++++++
 tb/tb_final_reduce.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/final_reduce.sv
// Final conditional-subtraction stage: repeatedly subtracts M from T via an external
// registered mpadder until T < M. Optional macro FINAL_REDUCE_ERR_EN adds an err port and a 4-subtraction cap.
module final_reduce (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [1026:0] t_in,
  input  logic [1023:0] m_in,
  output logic [1026:0] add_a,
  output logic [1026:0] add_b,
  output logic          add_sub,
  input  logic [1027:0] add_result,
  output logic [1023:0] result,
  output logic          done,
  output logic          busy
`ifdef FINAL_REDUCE_ERR_EN
  ,
  output logic          err
`endif
);

  typedef enum logic [1:0] {IDLE, SUB, CHK, DONE} state_t;

`ifdef FINAL_REDUCE_ERR_EN
  localparam int CNT_W = 3;
`else
  localparam int CNT_W = 8;
`endif

  state_t            state_q;
  logic [1026:0]     t_q;
  logic [1023:0]     m_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [1023:0]     result_q;
  logic              done_q;
`ifdef FINAL_REDUCE_ERR_EN
  logic              err_q;
`endif

  assign add_a   = t_q;
  assign add_b   = {3'b000, m_q};
  assign add_sub = 1'b1;
  assign result  = result_q;
  assign done    = done_q;
  assign busy    = (state_q != IDLE);

`ifdef FINAL_REDUCE_ERR_EN
  assign err = err_q;
`else
  // Without the cap the counter is only visible in waveforms.
  logic cnt_unused;
  assign cnt_unused = ^cnt_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      t_q      <= '0;
      m_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
`ifdef FINAL_REDUCE_ERR_EN
      err_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            t_q     <= t_in;
            m_q     <= m_in;
            cnt_q   <= '0;
`ifdef FINAL_REDUCE_ERR_EN
            err_q   <= 1'b0;
`endif
            state_q <= SUB;
          end
        end
        // Adder samples add_a/add_b at the end of this cycle; its result is read in CHK.
        SUB: state_q <= CHK;
        CHK: begin
          if (add_result[1027]) begin
            result_q <= t_q[1023:0];
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
`ifdef FINAL_REDUCE_ERR_EN
          else if (cnt_q == 3'd3) begin
            result_q <= add_result[1023:0];
            err_q    <= 1'b1;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
`endif
          else begin
            t_q     <= add_result[1026:0];
            cnt_q   <= cnt_q + 1'b1;
            state_q <= SUB;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_final_reduce.sv
// Scoreboard bench for final_reduce with a behavioural registered mpadder.
module tb_final_reduce;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [1026:0] t_in;
  logic [1023:0] m_in;
  logic [1026:0] add_a;
  logic [1026:0] add_b;
  logic          add_sub;
  logic [1027:0] add_result;
  logic [1023:0] result;
  logic          done;
  logic          busy;
`ifdef FINAL_REDUCE_ERR_EN
  logic          err;
`endif

  final_reduce dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .t_in       (t_in),
    .m_in       (m_in),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_sub    (add_sub),
    .add_result (add_result),
    .result     (result),
    .done       (done),
    .busy       (busy)
`ifdef FINAL_REDUCE_ERR_EN
    ,
    .err        (err)
`endif
  );

  always #5 clk = ~clk;

  // External adder: one-cycle registered a - b with borrow in bit 1027.
  always @(posedge clk) add_result <= {1'b0, add_a} - {1'b0, add_b};

  typedef struct {
    logic [1023:0] res;
    int            lat;
    logic          err;
  } exp_t;

  exp_t          sb[$];
  int            checks = 0;
  int            failures = 0;
  logic [1023:0] prev_res = '0;

  task automatic check(input string tag, input logic [1027:0] got, input logic [1027:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (low 128 bits)", tag, got[127:0], exp[127:0]);
    end
  endtask

  task automatic run_op(input logic [1026:0] t, input logic [1023:0] m,
                        input logic [1023:0] er, input int lat, input logic ee,
                        input bit disturb);
    exp_t e;
    int   cyc;
    bit   seen;
    @(negedge clk);
    t_in  = t;
    m_in  = m;
    start = 1'b1;
    e.res = er; e.lat = lat; e.err = ee;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    cyc   = 1;
    check("add_a_cap", 1028'(add_a), 1028'(t));
    check("add_b_cap", 1028'(add_b), {4'b0, m});
    check("add_sub", 1028'(add_sub), 1028'(1'b1));
    if (disturb) begin
      t_in = {$urandom, $urandom, $urandom};
      m_in = {$urandom, $urandom};
    end
    seen = 1'b0;
    while (!seen && cyc < 60) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (disturb) begin
          check("busy_mid", 1028'(busy), 1028'(1'b1));
          check("res_hold", 1028'(result), 1028'(prev_res));
          start = (cyc == 2);
        end
        @(posedge clk); #1;
        cyc++;
      end
    end
    start = 1'b0;
    e = sb.pop_front();
    check("done_seen", 1028'(seen), 1028'(1'b1));
    check("latency", 1028'(cyc), 1028'(e.lat));
    check("result", 1028'(result), 1028'(e.res));
`ifdef FINAL_REDUCE_ERR_EN
    check("err", 1028'(err), 1028'(e.err));
`endif
    prev_res = e.res;
    $display("op t=%0h m=%0h -> result=%0h cycles=%0d (low 32 bits shown)",
             t[31:0], m[31:0], result[31:0], cyc);
    @(posedge clk); #1;
    check("done_pulse", 1028'(done), 1028'(1'b0));
    check("busy_idle", 1028'(busy), 1028'(1'b0));
  endtask

  initial begin
    logic [1023:0] big;
    logic [1026:0] tt;
    logic [1023:0] rm;
    logic [1023:0] rr;
    int            q;

    reset = 1'b1; start = 1'b0; t_in = '0; m_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_result", 1028'(result), 1028'(0));
    check("rst_done", 1028'(done), 1028'(0));
    check("rst_busy", 1028'(busy), 1028'(0));
`ifdef FINAL_REDUCE_ERR_EN
    check("rst_err", 1028'(err), 1028'(0));
`endif
    @(negedge clk); reset = 1'b0;

    big = '0; big[1023] = 1'b1; big[0] = 1'b1;

    run_op(1027'd5, 1024'd7, 1024'd5, 3, 1'b0, 1'b0);
    run_op({3'b0, big}, big, 1024'd0, 5, 1'b0, 1'b0);
    tt = {3'b0, big} + {3'b0, big} + 1027'd3;
    run_op(tt, big, 1024'd3, 7, 1'b0, 1'b1);

    // Abort the same operation in CHK with an asynchronous reset.
    @(negedge clk);
    t_in = tt; m_in = big; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("abort_busy", 1028'(busy), 1028'(0));
    check("abort_result", 1028'(result), 1028'(0));
    check("abort_done", 1028'(done), 1028'(0));
    repeat (3) begin
      @(posedge clk); #1;
      check("abort_nodone", 1028'(done), 1028'(0));
    end
    @(negedge clk); reset = 1'b0;
    prev_res = '0;

    run_op(1027'd9, 1024'd4, 1024'd1, 7, 1'b0, 1'b0);

`ifdef FINAL_REDUCE_ERR_EN
    rm = '0; rm[1020] = 1'b1;
    tt = {3'b0, rm} + {3'b0, rm} + {3'b0, rm} + {3'b0, rm} + 1027'd5;
    run_op(tt, rm, 1024'd5, 9, 1'b1, 1'b0);
    run_op(1027'd1, 1024'd3, 1024'd1, 3, 1'b0, 1'b0);
`endif

    for (int n = 0; n < 4; n++) begin
      for (int w = 0; w < 32; w++) rm[w*32 +: 32] = $urandom;
      rm[1023] = 1'b1;
      for (int w = 0; w < 32; w++) rr[w*32 +: 32] = $urandom;
      rr = rr % rm;
      q  = n % 3;
      tt = {3'b0, rr};
      for (int j = 0; j < q; j++) tt = tt + {3'b0, rm};
      run_op(tt, rm, rr, 2 * (q + 1) + 1, 1'b0, (n == 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
